// File: rtl/tt_pg_pkg.sv
// Shared state type, default sizing and counter-width helper for the tile power-gate sequencer.
package tt_pg_pkg;

    typedef enum logic [2:0] {
        S_OFF,
        S_RAMP_UP,
        S_SETTLE,
        S_ISO_REL,
        S_ON,
        S_RST_ASSERT,
        S_ISO_ASSERT,
        S_RAMP_DN
    } tt_pg_seq_state_t;

    localparam int TT_PG_N_DEFAULT      = 4;
    localparam int TT_PG_STEP_DEFAULT   = 16;
    localparam int TT_PG_SETTLE_DEFAULT = 64;

    // Wide enough to hold the largest reload value without wrapping.
    function automatic int tt_pg_cnt_width(input int step_cyc, input int settle_cyc);
        int max_cyc;
        max_cyc = (step_cyc > settle_cyc) ? step_cyc : settle_cyc;
        return $clog2(max_cyc + 1);
    endfunction

endpackage

// File: rtl/tt_pg_tmr.sv
// Loadable down-counter; done_o is high while the count sits at zero.
// A load value of L makes done_o visible on the (L+1)-th edge after the load.
module tt_pg_tmr #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            // NOTE: non-blocking for every sequential update so all flops see pre-edge values.
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/tt_pg_seq.sv
// Power-up/power-down sequencer for the N_PG power-gate cells of one user tile.
// Define TT_PG_SEQ_STAGGER_DN_EN to release the gates MSB-first, one every STEP_CYC, on power-down.
module tt_pg_seq
    import tt_pg_pkg::*;
#(
    parameter int N_PG       = TT_PG_N_DEFAULT,
    parameter int STEP_CYC   = TT_PG_STEP_DEFAULT,
    parameter int SETTLE_CYC = TT_PG_SETTLE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_req,
    output logic [N_PG-1:0] pg_ctrl,
    output logic            iso_n,
    output logic            usr_rst_n,
    output logic            pwr_good,
    output logic            busy
);

    localparam int               CNT_W     = tt_pg_cnt_width(STEP_CYC, SETTLE_CYC);
    localparam logic [CNT_W-1:0] STEP_LD   = CNT_W'(STEP_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [N_PG-1:0]  PG_FIRST  = N_PG'(1);

    tt_pg_seq_state_t state_q;
    logic [N_PG-1:0]  pg_ctrl_q;
    logic             iso_n_q;
    logic             usr_rst_n_q;
    logic             pwr_good_q;
    logic             busy_q;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;
    logic [N_PG-1:0]  pg_fill;
    logic [N_PG-1:0]  pg_dn;

    tt_pg_tmr #(
        .CNT_W(CNT_W)
    ) u_tmr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .done_o    (tmr_done)
    );

    // Gates are thermometer-coded from bit 0, so shifting adds or drops the top gate.
    always_comb begin
        pg_fill = (pg_ctrl_q << 1) | PG_FIRST;
`ifdef TT_PG_SEQ_STAGGER_DN_EN
        pg_dn   = pg_ctrl_q >> 1;
`else
        pg_dn   = '0;
`endif
    end

    // The timer is reloaded on every state entry that times something, and on each step.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = STEP_LD;
        case (state_q)
            S_OFF: begin
                tmr_load = 1'b1;
                tmr_val  = (N_PG == 1) ? SETTLE_LD : STEP_LD;
            end
            S_RAMP_UP: begin
                if (!en_req) begin
                    tmr_load = 1'b1;
                end else if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = (pg_fill == '1) ? SETTLE_LD : STEP_LD;
                end
            end
            S_SETTLE:     tmr_load = !en_req;
            S_ISO_ASSERT: tmr_load = 1'b1;
            S_RAMP_DN:    tmr_load = tmr_done;
            default:      tmr_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_OFF;
            pg_ctrl_q   <= '0;
            iso_n_q     <= 1'b0;
            usr_rst_n_q <= 1'b0;
            pwr_good_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_OFF: begin
                    if (en_req) begin
                        pg_ctrl_q <= PG_FIRST;
                        busy_q    <= 1'b1;
                        state_q   <= (N_PG == 1) ? S_SETTLE : S_RAMP_UP;
                    end
                end
                S_RAMP_UP: begin
                    if (!en_req) begin
                        pg_ctrl_q <= pg_dn;
                        state_q   <= S_RAMP_DN;
                    end else if (tmr_done) begin
                        pg_ctrl_q <= pg_fill;
                        if (pg_fill == '1) begin
                            state_q <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (!en_req) begin
                        pg_ctrl_q <= pg_dn;
                        state_q   <= S_RAMP_DN;
                    end else if (tmr_done) begin
                        iso_n_q <= 1'b1;
                        state_q <= S_ISO_REL;
                    end
                end
                // en_req is deliberately ignored here: the tile always reaches ON first.
                S_ISO_REL: begin
                    usr_rst_n_q <= 1'b1;
                    pwr_good_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_ON;
                end
                S_ON: begin
                    if (!en_req) begin
                        usr_rst_n_q <= 1'b0;
                        pwr_good_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_RST_ASSERT;
                    end
                end
                S_RST_ASSERT: begin
                    iso_n_q <= 1'b0;
                    state_q <= S_ISO_ASSERT;
                end
                S_ISO_ASSERT: begin
                    pg_ctrl_q <= pg_dn;
                    state_q   <= S_RAMP_DN;
                end
                S_RAMP_DN: begin
                    if (pg_ctrl_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= S_OFF;
                    end
`ifdef TT_PG_SEQ_STAGGER_DN_EN
                    else if (tmr_done) begin
                        pg_ctrl_q <= pg_dn;
                    end
`endif
                end
                default: state_q <= S_OFF;
            endcase
        end
    end

    assign pg_ctrl   = pg_ctrl_q;
    assign iso_n     = iso_n_q;
    assign usr_rst_n = usr_rst_n_q;
    assign pwr_good  = pwr_good_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_tt_pg_seq.sv
// Bench for tt_pg_seq: default instance plus an N_PG=1/STEP=1/SETTLE=1 instance,
// both compared every cycle against a closed-form timeline model.
module tb_tt_pg_seq;
    import tt_pg_pkg::*;

`ifdef TT_PG_SEQ_STAGGER_DN_EN
    localparam bit STAGGER = 1'b1;
`else
    localparam bit STAGGER = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic en_a;
    logic en_b;

    logic [TT_PG_N_DEFAULT-1:0] pg_a;
    logic                       iso_a, urst_a, good_a, busy_a;
    logic [0:0]                 pg_b;
    logic                       iso_b, urst_b, good_b, busy_b;

    tt_pg_seq u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_req   (en_a),
        .pg_ctrl  (pg_a),
        .iso_n    (iso_a),
        .usr_rst_n(urst_a),
        .pwr_good (good_a),
        .busy     (busy_a)
    );

    tt_pg_seq #(
        .N_PG      (1),
        .STEP_CYC  (1),
        .SETTLE_CYC(1)
    ) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_req   (en_b),
        .pg_ctrl  (pg_b),
        .iso_n    (iso_b),
        .usr_rst_n(urst_b),
        .pwr_good (good_b),
        .busy     (busy_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_k   = 0;
    int hold_a   = 0;
    int hold_b   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, edge_k, got, exp);
        end
    endtask

    // Timeline model: a power-up started at edge s has (1 + t/STEP) gates on at t = k - s,
    // isolation released at t_iso = (N-1)*STEP + SETTLE and reset released one edge later.
    typedef enum {M_OFF, M_UP, M_DN} mmode_e;
    typedef struct {
        int     n;
        int     step;
        int     settle;
        mmode_e mode;
        int     up_start;
        int     dn_start;
        int     dn_gates;
        int     dn_delay;
        int     gates;
        bit     iso;
        bit     rst;
        bit     busy;
    } mdl_t;

    mdl_t mdl [2];

    task automatic model_reset(input int i);
        mdl[i].mode  = M_OFF;
        mdl[i].gates = 0;
        mdl[i].iso   = 1'b0;
        mdl[i].rst   = 1'b0;
        mdl[i].busy  = 1'b0;
    endtask

    task automatic model_edge(input int i, input bit en);
        mdl_t m;
        int   t_iso, t_pre, t, u, off_u, g;
        m     = mdl[i];
        t_iso = (m.n - 1) * m.step + m.settle;
        case (m.mode)
            M_OFF: begin
                if (en) begin
                    m.mode     = M_UP;
                    m.up_start = edge_k;
                end
            end
            M_UP: begin
                t_pre = edge_k - 1 - m.up_start;
                // The edge right after isolation release always completes the power-up.
                if (!en && t_pre != t_iso) begin
                    m.mode     = M_DN;
                    m.dn_start = edge_k;
                    if (t_pre < t_iso) begin
                        g          = 1 + t_pre / m.step;
                        m.dn_gates = (g > m.n) ? m.n : g;
                        m.dn_delay = 0;
                    end else begin
                        m.dn_gates = m.n;
                        m.dn_delay = 2;
                    end
                end
            end
            default: begin
                off_u = m.dn_delay + 1 + (STAGGER ? (m.dn_gates - 1) * m.step : 0);
                if (edge_k - m.dn_start == off_u) m.mode = M_OFF;
            end
        endcase
        m.gates = 0;
        m.iso   = 1'b0;
        m.rst   = 1'b0;
        m.busy  = 1'b0;
        case (m.mode)
            M_UP: begin
                t       = edge_k - m.up_start;
                g       = 1 + t / m.step;
                m.gates = (g > m.n) ? m.n : g;
                m.iso   = (t >= t_iso);
                m.rst   = (t > t_iso);
                m.busy  = !m.rst;
            end
            M_DN: begin
                u      = edge_k - m.dn_start;
                m.busy = 1'b1;
                m.iso  = (m.dn_delay == 2 && u == 0);
                if (u < m.dn_delay) begin
                    g = m.dn_gates;
                end else if (STAGGER) begin
                    g = m.dn_gates - 1 - (u - m.dn_delay) / m.step;
                end else begin
                    g = 0;
                end
                m.gates = (g < 0) ? 0 : g;
            end
            default: m.gates = 0;
        endcase
        mdl[i] = m;
    endtask

    task automatic check_dut(input string nm, input int i, input logic [31:0] pg,
                             input logic iso, input logic urst, input logic good, input logic bsy);
        logic [31:0] all_on;
        all_on = 32'((1 << mdl[i].n) - 1);
        check({nm, ".pg_ctrl"},   pg,         32'((1 << mdl[i].gates) - 1));
        check({nm, ".iso_n"},     32'(iso),   32'(mdl[i].iso));
        check({nm, ".usr_rst_n"}, 32'(urst),  32'(mdl[i].rst));
        check({nm, ".pwr_good"},  32'(good),  32'(mdl[i].rst));
        check({nm, ".busy"},      32'(bsy),   32'(mdl[i].busy));
        check({nm, ".inv_iso_pg"},  32'(iso && (pg != all_on)), 32'd0);
        check({nm, ".inv_rst_iso"}, 32'(urst && !iso),          32'd0);
        check({nm, ".inv_good"},    32'(good != urst),          32'd0);
    endtask

    task automatic cycle();
        @(posedge clk);
        edge_k++;
        if (rst_n) begin
            model_edge(0, en_a);
            model_edge(1, en_b);
        end else begin
            model_reset(0);
            model_reset(1);
        end
        #1;
        check_dut("a", 0, 32'(pg_a), iso_a, urst_a, good_a, busy_a);
        check_dut("b", 1, 32'(pg_b), iso_b, urst_b, good_b, busy_b);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        mdl[0].n = TT_PG_N_DEFAULT;  mdl[0].step = TT_PG_STEP_DEFAULT;  mdl[0].settle = TT_PG_SETTLE_DEFAULT;
        mdl[1].n = 1;                mdl[1].step = 1;                   mdl[1].settle = 1;
        model_reset(0);
        model_reset(1);
        rst_n = 1'b0;
        en_a  = 1'b0;
        en_b  = 1'b0;
        run(3);
        rst_n = 1'b1;
        run(2);

        // Power-up with fixed timestamps from the first sampling edge.
        en_a = 1'b1;
        en_b = 1'b1;
        cycle();
        check("a.first_gate", 32'(pg_a), 32'h1);
        check("b.first_gate", 32'(pg_b), 32'h1);
        check("b.iso_early",  32'(iso_b), 32'd0);
        cycle();
        check("b.iso_at_2",   32'(iso_b), 32'd1);
        check("b.rst_at_2",   32'(urst_b), 32'd0);
        cycle();
        check("b.rst_at_3",   32'(urst_b), 32'd1);
        run(109);
        check("a.all_gates_112", 32'(pg_a), 32'hf);
        check("a.iso_112",       32'(iso_a), 32'd0);
        cycle();
        check("a.iso_113",  32'(iso_a), 32'd1);
        check("a.rst_113",  32'(urst_a), 32'd0);
        check("a.busy_113", 32'(busy_a), 32'd1);
        cycle();
        check("a.rst_114",  32'(urst_a), 32'd1);
        check("a.busy_114", 32'(busy_a), 32'd0);
        run(16);

        // Normal power-down from ON.
        en_a = 1'b0;
        en_b = 1'b0;
        run(70);

        // Abort during the ramp with two gates on.
        en_a = 1'b1;
        run(20);
        en_a = 1'b0;
        run(50);

        // Re-request during ISO_ASSERT: power-down completes, then a fresh ramp.
        en_a = 1'b1;
        run(130);
        en_a = 1'b0;
        run(2);
        en_a = 1'b1;
        run(200);

        // Asynchronous reset in the middle of SETTLE.
        en_a = 1'b0;
        run(80);
        en_a = 1'b1;
        run(60);
        #3;
        rst_n = 1'b0;
        #1;
        check("a.async_pg",   32'(pg_a),   32'd0);
        check("a.async_iso",  32'(iso_a),  32'd0);
        check("a.async_rst",  32'(urst_a), 32'd0);
        check("a.async_good", 32'(good_a), 32'd0);
        check("a.async_busy", 32'(busy_a), 32'd0);
        check("b.async_pg",   32'(pg_b),   32'd0);
        model_reset(0);
        model_reset(1);
        run(3);
        rst_n = 1'b1;
        run(130);

        // Randomised request patterns on both instances.
        for (int i = 0; i < 3000; i++) begin
            if (hold_a == 0) begin
                en_a   = 1'($urandom_range(0, 1));
                hold_a = $urandom_range(1, 140);
            end
            if (hold_b == 0) begin
                en_b   = 1'($urandom_range(0, 1));
                hold_b = $urandom_range(1, 8);
            end
            hold_a--;
            hold_b--;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tt_pg_seq.md
Name: tt_pg_seq

Overview:
- Power-up/power-down sequencer that drives the `ctrl` inputs of N_PG parallel 1v8 power-gate cells (tt_pg_1v8_ll_4) for one user tile.
- Sits directly upstream of the power-gate cells. Takes a tile enable request from the mux controller.
- Staggers gate turn-on to limit inrush current, waits a settle time, then releases isolation and then the user reset.
- Reverses the sequence on power-down.

Parameters:
- N_PG, 4: number of power-gate cells driven; one pg_ctrl bit each; must be >= 1.
- STEP_CYC, 16: clock cycles between successive gate enables (and disables when staggered); must be >= 1.
- SETTLE_CYC, 64: clock cycles from the last gate enable to isolation release; must be >= 1.

Ports:
- clk  input  1  sequencer clock.
- rst_n  input  1  asynchronous active-low reset.
- en_req  input  1  tile power request; level-sensitive; synchronous to clk (synchronisation is the caller's responsibility).
- pg_ctrl  output  N_PG  one bit per power-gate `ctrl` input; 1 = gate conducting.
- iso_n  output  1  output isolation control; 0 = tile outputs clamped.
- usr_rst_n  output  1  reset to the gated user design; active low.
- pwr_good  output  1  1 only while the tile is fully on and out of reset.
- busy  output  1  1 while in any transitional state (not OFF, not ON).

Interface fixed: one clock `clk`; reset `rst_n` is asynchronous, active-low.

Behaviour:
- All outputs are registered.
- Reset value of every output:
  - pg_ctrl = 0, iso_n = 0, usr_rst_n = 0, pwr_good = 0, busy = 0.
  - State = OFF.
  - Reset asserted mid-sequence forces these values immediately, with no staggering.
- States: OFF, RAMP_UP, SETTLE, ISO_REL, ON, RST_ASSERT, ISO_ASSERT, RAMP_DN.
- OFF:
  - All outputs at reset values.
  - en_req = 1 sampled at edge E -> RAMP_UP, with pg_ctrl[0] = 1 after E+1.
- RAMP_UP:
  - pg_ctrl[i] rises at E+1+i*STEP_CYC.
  - Bits are set LSB first and are thermometer-coded; they are never cleared during RAMP_UP.
  - When the last bit is set -> SETTLE.
- SETTLE:
  - Counts SETTLE_CYC cycles.
  - iso_n rises at E+1+(N_PG-1)*STEP_CYC+SETTLE_CYC (state ISO_REL).
- ISO_REL: one cycle, then -> ON.
  - usr_rst_n = 1 and pwr_good = 1 one cycle after iso_n rises.
  - With defaults: pg_ctrl = 0001/0011/0111/1111 at E+1/17/33/49; iso_n at E+113; usr_rst_n and pwr_good at E+114.
- ON, en_req = 0 sampled at edge T:
  - usr_rst_n = 0 and pwr_good = 0 at T+1 (RST_ASSERT).
  - iso_n = 0 at T+2 (ISO_ASSERT).
  - Then RAMP_DN; pg_ctrl handling per the Optional Feature.
- Abort: en_req = 0 sampled in RAMP_UP or SETTLE -> RAMP_DN next cycle.
  - RST_ASSERT and ISO_ASSERT are skipped, since reset and isolation are still asserted.
  - The step counter is discarded.
- en_req toggling:
  - en_req = 1 during RST_ASSERT, ISO_ASSERT or RAMP_DN is ignored; power-down always completes to OFF.
  - From OFF, if en_req is still 1, a new ramp starts on the next edge (minimum one cycle in OFF).
  - en_req = 0 in ISO_REL is treated as in ON (the sequence continues through ON, then powers down).
- Invariants the bench checks every cycle:
  - iso_n = 1 implies pg_ctrl is all-ones.
  - usr_rst_n = 1 implies iso_n = 1.
  - pwr_good == usr_rst_n.
- Counter width is $clog2(max(STEP_CYC, SETTLE_CYC)+1). No wrap is possible; the counter reloads on every state entry.

Optional Feature:
- Macro: TT_PG_SEQ_STAGGER_DN_EN.
- Without the macro: in RAMP_DN, all pg_ctrl bits clear on the first RAMP_DN edge, then -> OFF. Normal power-down gives pg_ctrl = 0 at T+3.
- With the macro: RAMP_DN clears the highest set bit on its first edge, then one more bit every STEP_CYC cycles (MSB first).
  - -> OFF when pg_ctrl = 0.
  - With defaults: 0111/0011/0001/0000 at T+3/19/35/51.
  - On abort, clearing starts from the highest bit currently set.

Decomposition:
- Package tt_pg_pkg holds:
  - the state enum typedef tt_pg_seq_state_t;
  - default constants TT_PG_N_DEFAULT, TT_PG_STEP_DEFAULT, TT_PG_SETTLE_DEFAULT.
- One sub-module, tt_pg_tmr: loadable down-counter with a `done` flag, shared by the ramp and settle timing.
- The FSM and output registers live in tt_pg_seq.

Test Plan:
- Reset, then en_req = 1 at edge 0 (defaults) -> pg_ctrl 0001@1, 0011@17, 0111@33, 1111@49; iso_n@113; usr_rst_n = pwr_good = 1@114; busy = 1 on edges 1..113, 0 at 114.
- From ON, en_req = 0 at T -> usr_rst_n = 0@T+1, iso_n = 0@T+2, pg_ctrl = 0@T+3; with the macro, 0111@T+3, 0011@T+19, 0001@T+35, 0000@T+51.
- en_req = 0 at edge 20 of a ramp (pg_ctrl = 0011) -> iso_n and usr_rst_n never rise; pg_ctrl = 0 at 21 (macro: 0001@21, 0000@37); busy = 0 once OFF.
- en_req pulsed back to 1 during ISO_ASSERT -> full power-down to OFF, then ramp restarts and pg_ctrl[0] = 1 one edge after OFF is reached.
- rst_n asserted asynchronously mid-SETTLE -> all outputs 0 immediately (same delta, no clock edge); after release with en_req = 1, full sequence repeats from 0001.
- Parameter sweep N_PG = 1, STEP_CYC = 1, SETTLE_CYC = 1: en_req = 1@0 -> pg_ctrl = 1@1, iso_n@2, usr_rst_n@3; the three invariants hold every cycle.
